// File: rtl/i2s_transmitter.sv
// I2S (Philips) transmitter: sends the mixer's mono offset-binary sample as two's complement
// in both slots of each frame. It generates BCLK/LRCLK from clk and requests a new sample once per frame.
module i2s_transmitter #(
  parameter int AUDIO_BIT_WIDTH = 16,  // keep equal to the mixer output width
  parameter int BCLK_DIV        = 4,
  parameter int SLOT_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [AUDIO_BIT_WIDTH-1:0] audio_in,
  output logic                       sample_request,
  output logic                       bclk,
  output logic                       lrclk,
  output logic                       sdata
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);
  localparam logic [BIT_W-1:0] SLOT_K   = BIT_W'(SLOT_WIDTH);

  generate
    if (SLOT_WIDTH < AUDIO_BIT_WIDTH + 1) begin : g_bad_slot
      $error("i2s_transmitter: SLOT_WIDTH must be at least AUDIO_BIT_WIDTH+1");
    end
    if (BCLK_DIV < 1) begin : g_bad_div
      $error("i2s_transmitter: BCLK_DIV must be at least 1");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state_q, state_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [AUDIO_BIT_WIDTH-1:0] hold_q, hold_d;
  logic                       bclk_q, bclk_d;
  logic                       lrclk_q, lrclk_d;
  logic                       sdata_q, sdata_d;
  logic                       sreq_q, sreq_d;

  logic [AUDIO_BIT_WIDTH-1:0] audio_tc;
  logic [BIT_W-1:0]           bit_nxt;
  logic [BIT_W-1:0]           slot_k;
  logic                       bit_val;

  // Offset binary to two's complement is just an MSB flip.
  assign audio_tc = audio_in ^ {1'b1, {(AUDIO_BIT_WIDTH-1){1'b0}}};

  always_comb begin
    bit_nxt = (bit_q == BIT_LAST) ? '0 : bit_q + BIT_W'(1);
    slot_k  = (bit_nxt >= SLOT_K) ? bit_nxt - SLOT_K : bit_nxt;
    // Slot position 0 is the I2S one-bit delay; positions 1..W carry the word MSB first.
    bit_val = 1'b0;
    for (int i = 0; i < AUDIO_BIT_WIDTH; i++) begin
      if (slot_k == BIT_W'(AUDIO_BIT_WIDTH - i)) bit_val = hold_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    bclk_d  = bclk_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    sreq_d  = 1'b0;
    case (state_q)
      IDLE: begin
        bclk_d  = 1'b0;
        lrclk_d = 1'b0;
        sdata_d = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        if (enable) begin
          state_d = RUN;
          hold_d  = audio_tc;
          sreq_d  = 1'b1;
        end
      end
      RUN: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
          bclk_d = ~bclk_q;
          // Data and word select change on the falling BCLK edge.
          if (bclk_q) begin
            bit_d   = bit_nxt;
            lrclk_d = (bit_nxt >= SLOT_K);
            sdata_d = bit_val;
            if (bit_q == BIT_LAST) begin
              lrclk_d = 1'b0;
              sdata_d = 1'b0;
              if (enable) begin
                hold_d = audio_tc;
                sreq_d = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      sreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      sreq_q  <= sreq_d;
    end
  end

  assign sample_request = sreq_q;
  assign bclk           = bclk_q;
  assign lrclk          = lrclk_q;
  assign sdata          = sdata_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: the driver predicts each frame from the sample it offered, and
// a negedge monitor checks sample_request timing and every bit seen at a BCLK rise.
module tb_i2s_transmitter;

  localparam int AW    = 16;
  localparam int FRAME = 512;  // 4 * SLOT_WIDTH * BCLK_DIV

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [AW-1:0] audio_in;
  logic          sample_request;
  logic          bclk;
  logic          lrclk;
  logic          sdata;

  i2s_transmitter #(
    .AUDIO_BIT_WIDTH(AW),
    .BCLK_DIV(4),
    .SLOT_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .audio_in(audio_in),
    .sample_request(sample_request),
    .bclk(bclk),
    .lrclk(lrclk),
    .sdata(sdata)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [31:0] exp_req_q[$];   // negedge cycle on which sample_request must be seen
  logic [33:0] exp_q[$];       // {rise cycle, lrclk, sdata} for each BCLK rise
  int          vectors     = 0;
  int          miscompares = 0;
  logic        idle_expect = 1'b0;
  logic        bclk_prev   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: the slot carries a 0 (one-bit delay), the two's-complement word MSB first,
  // then zeros; left slot then right slot, both with the same word.
  task automatic push_frame(input logic [AW-1:0] a, input int start);
    logic [AW-1:0] word;
    int            k;
    logic          sd;
    word = a ^ 16'h8000;
    exp_req_q.push_back(32'(start));
    for (int j = 0; j < 64; j++) begin
      k  = j % 32;
      sd = (k >= 1 && k <= AW) ? word[AW - k] : 1'b0;
      exp_q.push_back({32'(start + 4 + 8 * j), (j >= 32), sd});
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [31:0] er;
    logic [33:0] eb;
    if (sample_request) begin
      if (exp_req_q.size() == 0) chk("sreq_unexpected", 32'd1, 32'd0);
      else begin
        er = exp_req_q.pop_front();
        chk("sreq_cycle", 32'(cyc), er);
      end
    end
    if (bclk && !bclk_prev) begin
      if (exp_q.size() == 0) chk("bclk_rise_unexpected", 32'd1, 32'd0);
      else begin
        eb = exp_q.pop_front();
        chk("bclk_rise_cycle", 32'(cyc), eb[33:2]);
        chk("lrclk_bit", {31'd0, lrclk}, {31'd0, eb[1]});
        chk("sdata_bit", {31'd0, sdata}, {31'd0, eb[0]});
      end
    end
    if (idle_expect)
      chk("idle_outputs", {28'd0, bclk, lrclk, sdata, sample_request}, 32'd0);
    bclk_prev = bclk;
  end

  // driver: called on a negedge with the DUT idle. mode 0 = fixed sample, 1 = random every cycle.
  // enable drops drop_off clocks into the last frame; blip drops it briefly inside frame 1.
  task automatic run_frames(input int nframes, input int drop_off, input int mode,
                            input logic [AW-1:0] fixed, input bit blip);
    int            c;
    logic [AW-1:0] a;
    c = cyc;
    idle_expect = 1'b0;
    enable = 1'b1;
    for (int t = 0; t < nframes * FRAME; t++) begin
      if (t == (nframes - 1) * FRAME + drop_off) enable = 1'b0;
      if (blip && t == FRAME + 100) enable = 1'b0;
      if (blip && t == FRAME + 300) enable = 1'b1;
      a = (mode == 0) ? fixed : AW'($urandom);
      audio_in = a;
      if (t % FRAME == 0) push_frame(a, c + 1 + t);
      @(negedge clk);
    end
    audio_in = AW'($urandom);
    @(negedge clk);
    chk("req_q_drained", 32'(exp_req_q.size()), 32'd0);
    chk("bit_q_drained", 32'(exp_q.size()), 32'd0);
    idle_expect = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    enable = 1'b0;
    audio_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {28'd0, bclk, lrclk, sdata, sample_request}, 32'd0);
    rst_n = 1'b1;

    // enable low: everything stays quiet
    idle_expect = 1'b1;
    repeat (1000) @(negedge clk);

    // fixed patterns, enable dropped at bit 10 of the left slot
    run_frames(1, 82, 0, 16'hFFFF, 1'b0);
    run_frames(1, 82, 0, 16'h8000, 1'b0);
    run_frames(1, 82, 0, 16'h0000, 1'b0);
    // continuous random run, with a short enable dip that must not break framing
    run_frames(4, 400, 1, 16'h0000, 1'b1);
    // drop mid-frame, stay idle, then restart
    run_frames(2, 82, 1, 16'h0000, 1'b0);
    repeat (20) @(negedge clk);

    // asynchronous reset in the right slot
    c = cyc;
    idle_expect = 1'b0;
    enable = 1'b1;
    audio_in = 16'h1234;
    push_frame(16'h1234, c + 1);
    repeat (320) @(negedge clk);
    chk("pre_reset_bclk_lrclk", {30'd0, bclk, lrclk}, 32'd3);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {28'd0, bclk, lrclk, sdata, sample_request}, 32'd0);
    exp_q.delete();
    exp_req_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_frames(2, 300, 1, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
